// File: rtl/mod_n_updown_counter_if.sv
// Control and status bundle for the modulo-N up/down counter.
// The master drives the controls; the slave (the counter) returns the count and its pulses.
interface mod_n_updown_counter_if #(
   parameter int WIDTH = 2
);
   logic             en;
   logic             up_dn;
   logic             load;
   logic [WIDTH-1:0] load_val;
   logic [WIDTH-1:0] count;
   logic             tc;
   logic             wrap;
   logic             load_err;

   modport master (
      output en, up_dn, load, load_val,
      input  count, tc, wrap, load_err
   );

   modport slave (
      input  en, up_dn, load, load_val,
      output count, tc, wrap, load_err
   );
endinterface

// File: rtl/mod_n_updown_counter.sv
// Parametrised modulo-N up/down counter with clamped synchronous load,
// combinational terminal count for cascading, and registered wrap/load-error pulses.
module mod_n_updown_counter #(
   parameter int WIDTH   = 2,
   parameter int MODULUS = 4
) (
   input  logic                      clk1,
   input  logic                      clr,
   mod_n_updown_counter_if.slave     bus
);

   if (MODULUS < 2 || MODULUS > (2 ** WIDTH)) begin : g_bad_modulus
      $error("mod_n_updown_counter: MODULUS must satisfy 2 <= MODULUS <= 2**WIDTH");
   end

   localparam logic [WIDTH-1:0] MAX = WIDTH'(MODULUS - 1);

   logic [WIDTH-1:0] r_count;
   logic             r_wrap;
   logic             r_load_err;

   logic [WIDTH-1:0] w_count_nxt;
   logic             w_wrap_nxt;
   logic             w_load_err_nxt;
   logic             w_at_max;
   logic             w_at_zero;

   // Out-of-range load values saturate to the top of the count range.
   function automatic logic [WIDTH-1:0] f_clamp_load(input logic [WIDTH-1:0] v);
      return (v > MAX) ? MAX : v;
   endfunction

   function automatic logic f_load_oor(input logic [WIDTH-1:0] v);
      return (v > MAX);
   endfunction

   assign w_at_max  = (r_count == MAX);
   assign w_at_zero = (r_count == '0);

   always_comb begin
      w_count_nxt    = r_count;
      w_wrap_nxt     = 1'b0;
      w_load_err_nxt = 1'b0;
      if (bus.load) begin
         w_count_nxt    = f_clamp_load(bus.load_val);
         w_load_err_nxt = f_load_oor(bus.load_val);
      end else if (bus.en) begin
         if (bus.up_dn) begin
            w_count_nxt = w_at_max ? '0 : r_count + WIDTH'(1);
            w_wrap_nxt  = w_at_max;
         end else begin
            w_count_nxt = w_at_zero ? MAX : r_count - WIDTH'(1);
            w_wrap_nxt  = w_at_zero;
         end
      end
   end

   always_ff @(posedge clk1 or posedge clr) begin
      if (clr) begin
         r_count    <= '0;
         r_wrap     <= 1'b0;
         r_load_err <= 1'b0;
      end else begin
         r_count    <= w_count_nxt;
         r_wrap     <= w_wrap_nxt;
         r_load_err <= w_load_err_nxt;
      end
   end

   // tc is unregistered so a cascaded stage steps on the same edge as this one.
   assign bus.tc       = bus.en & ~bus.load & (bus.up_dn ? w_at_max : w_at_zero);
   assign bus.count    = r_count;
   assign bus.wrap     = r_wrap;
   assign bus.load_err = r_load_err;

endmodule

// File: tb/tb_mod_n_updown_counter.sv
// Directed bench for mod_n_updown_counter: mod-4 default, mod-60 vector table,
// async clear, and a mod-10 / mod-6 cascade.
module tb_mod_n_updown_counter;

   logic clk1 = 1'b0;
   logic clr_a, clr_b, clr_c;
   int   n_vec = 0;
   int   n_err = 0;

   always #5 clk1 = ~clk1;

   mod_n_updown_counter_if #(.WIDTH(2)) if_a ();
   mod_n_updown_counter_if #(.WIDTH(6)) if_b ();
   mod_n_updown_counter_if #(.WIDTH(4)) if_lo ();
   mod_n_updown_counter_if #(.WIDTH(4)) if_hi ();

   mod_n_updown_counter u_a (.clk1(clk1), .clr(clr_a), .bus(if_a));
   mod_n_updown_counter #(.WIDTH(6), .MODULUS(60)) u_b (.clk1(clk1), .clr(clr_b), .bus(if_b));
   mod_n_updown_counter #(.WIDTH(4), .MODULUS(10)) u_lo (.clk1(clk1), .clr(clr_c), .bus(if_lo));
   mod_n_updown_counter #(.WIDTH(4), .MODULUS(6))  u_hi (.clk1(clk1), .clr(clr_c), .bus(if_hi));

   assign if_hi.en = if_lo.tc;

   typedef struct {
      logic       en;
      logic       up_dn;
      logic       load;
      logic [5:0] lv;
      logic       tc;
      logic [5:0] cnt;
      logic       wrap;
      logic       err;
   } vec_t;

   vec_t tbl[18];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic tick();
      @(posedge clk1);
      #1;
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not finish, expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      int exp_c;
      int n_hiwrap;

      // vector table for the mod-60 instance: {en, up_dn, load, load_val, tc_before, count, wrap, load_err}
      tbl[0]  = '{1'b0, 1'b1, 1'b1, 6'd58, 1'b0, 6'd58, 1'b0, 1'b0};
      tbl[1]  = '{1'b1, 1'b1, 1'b0, 6'd0,  1'b0, 6'd59, 1'b0, 1'b0};
      tbl[2]  = '{1'b1, 1'b1, 1'b0, 6'd0,  1'b1, 6'd0,  1'b1, 1'b0};
      tbl[3]  = '{1'b1, 1'b0, 1'b0, 6'd0,  1'b1, 6'd59, 1'b1, 1'b0};
      tbl[4]  = '{1'b0, 1'b1, 1'b0, 6'd0,  1'b0, 6'd59, 1'b0, 1'b0};
      tbl[5]  = '{1'b0, 1'b1, 1'b1, 6'd63, 1'b0, 6'd59, 1'b0, 1'b1};
      tbl[6]  = '{1'b0, 1'b1, 1'b1, 6'd60, 1'b0, 6'd59, 1'b0, 1'b1};
      tbl[7]  = '{1'b0, 1'b1, 1'b1, 6'd12, 1'b0, 6'd12, 1'b0, 1'b0};
      tbl[8]  = '{1'b0, 1'b1, 1'b0, 6'd0,  1'b0, 6'd12, 1'b0, 1'b0};
      tbl[9]  = '{1'b0, 1'b1, 1'b1, 6'd59, 1'b0, 6'd59, 1'b0, 1'b0};
      tbl[10] = '{1'b1, 1'b1, 1'b1, 6'd5,  1'b0, 6'd5,  1'b0, 1'b0};
      tbl[11] = '{1'b1, 1'b1, 1'b0, 6'd0,  1'b0, 6'd6,  1'b0, 1'b0};
      tbl[12] = '{1'b1, 1'b0, 1'b0, 6'd0,  1'b0, 6'd5,  1'b0, 1'b0};
      tbl[13] = '{1'b0, 1'b0, 1'b1, 6'd0,  1'b0, 6'd0,  1'b0, 1'b0};
      tbl[14] = '{1'b1, 1'b0, 1'b0, 6'd0,  1'b1, 6'd59, 1'b1, 1'b0};
      tbl[15] = '{1'b1, 1'b0, 1'b0, 6'd0,  1'b0, 6'd58, 1'b0, 1'b0};
      tbl[16] = '{1'b1, 1'b0, 1'b1, 6'd63, 1'b0, 6'd59, 1'b0, 1'b1};
      tbl[17] = '{1'b1, 1'b1, 1'b0, 6'd0,  1'b1, 6'd0,  1'b1, 1'b0};

      if_a.en = 1'b0;  if_a.up_dn = 1'b1;  if_a.load = 1'b0;  if_a.load_val = '0;
      if_b.en = 1'b0;  if_b.up_dn = 1'b1;  if_b.load = 1'b0;  if_b.load_val = '0;
      if_lo.en = 1'b0; if_lo.up_dn = 1'b1; if_lo.load = 1'b0; if_lo.load_val = '0;
      if_hi.up_dn = 1'b1; if_hi.load = 1'b0; if_hi.load_val = '0;
      clr_a = 1'b0; clr_b = 1'b0; clr_c = 1'b0;
      #1;
      clr_a = 1'b1; clr_b = 1'b1; clr_c = 1'b1;
      #1;
      chk("rst_count_a", 32'(if_a.count), 0);
      chk("rst_wrap_a",  32'(if_a.wrap), 0);
      chk("rst_err_a",   32'(if_a.load_err), 0);
      if_a.en = 1'b1;
      tick();
      tick();
      chk("rst_hold_a", 32'(if_a.count), 0);
      clr_a = 1'b0; clr_b = 1'b0; clr_c = 1'b0;
      if_a.en = 1'b0;

      // mod-4 free count: 0,1,2,3,0,1,2
      tick();
      if_a.en = 1'b1; if_a.up_dn = 1'b1;
      exp_c = 0;
      for (int i = 0; i < 6; i++) begin
         #1;
         chk("m4_tc", 32'(if_a.tc), (exp_c == 3) ? 1 : 0);
         tick();
         exp_c = (exp_c + 1) % 4;
         chk("m4_count", 32'(if_a.count), 32'(exp_c));
         chk("m4_wrap",  32'(if_a.wrap), (exp_c == 0) ? 1 : 0);
      end
      if_a.en = 1'b0;

      // mod-60 vector table
      for (int i = 0; i < 18; i++) begin
         if_b.en = tbl[i].en; if_b.up_dn = tbl[i].up_dn;
         if_b.load = tbl[i].load; if_b.load_val = tbl[i].lv;
         #1;
         chk($sformatf("m60_tc[%0d]", i), 32'(if_b.tc), 32'(tbl[i].tc));
         tick();
         chk($sformatf("m60_count[%0d]", i), 32'(if_b.count), 32'(tbl[i].cnt));
         chk($sformatf("m60_wrap[%0d]", i),  32'(if_b.wrap), 32'(tbl[i].wrap));
         chk($sformatf("m60_err[%0d]", i),   32'(if_b.load_err), 32'(tbl[i].err));
      end

      // async clear mid-cycle at count 37
      if_b.en = 1'b0; if_b.load = 1'b1; if_b.load_val = 6'd37;
      tick();
      if_b.load = 1'b0; if_b.en = 1'b1; if_b.up_dn = 1'b1;
      chk("clr_pre_count", 32'(if_b.count), 37);
      #2;
      clr_b = 1'b1;
      #1;
      chk("clr_async_count", 32'(if_b.count), 0);
      chk("clr_async_wrap",  32'(if_b.wrap), 0);
      chk("clr_async_err",   32'(if_b.load_err), 0);
      tick();
      tick();
      chk("clr_hold_count", 32'(if_b.count), 0);
      #2;
      clr_b = 1'b0;
      tick();
      chk("clr_release_count", 32'(if_b.count), 1);
      if_b.en = 1'b0;

      // dropped wrap pulse and falling tc on clear
      if_a.load = 1'b1; if_a.load_val = 2'd3;
      tick();
      if_a.load = 1'b0; if_a.en = 1'b1; if_a.up_dn = 1'b1;
      #1;
      chk("tc_before_clr", 32'(if_a.tc), 1);
      tick();
      chk("wrap_before_clr", 32'(if_a.wrap), 1);
      if_a.up_dn = 1'b0;
      #1;
      clr_a = 1'b1;
      #1;
      chk("wrap_dropped", 32'(if_a.wrap), 0);
      if_a.up_dn = 1'b1;
      if_a.load = 1'b1; if_a.load_val = 2'd3;
      clr_a = 1'b0;
      tick();
      if_a.load = 1'b0;
      #1;
      chk("tc_at3_again", 32'(if_a.tc), 1);
      clr_a = 1'b1;
      #1;
      chk("tc_falls_on_clr", 32'(if_a.tc), 0);
      clr_a = 1'b0;
      if_a.en = 1'b0;

      // cascade mod-10 units, mod-6 tens: 60 clocks from 00
      clr_c = 1'b1;
      #1;
      clr_c = 1'b0;
      if_lo.en = 1'b1; if_lo.up_dn = 1'b1;
      n_hiwrap = 0;
      for (int k = 1; k <= 60; k++) begin
         tick();
         chk($sformatf("casc[%0d]", k), 32'(if_hi.count) * 10 + 32'(if_lo.count), 32'(k % 60));
         if (if_hi.wrap) n_hiwrap++;
      end
      chk("casc_hi_wrap_count", 32'(n_hiwrap), 1);
      if_lo.en = 1'b0;

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule

// File: doc/mod_n_updown_counter.md
Name: mod_n_updown_counter

Overview:
- Parametrised modulo-N synchronous counter, successor to the fixed 2-bit wrap counter.
- Adds enable, up/down direction, synchronous load with range clamping, and cascade terminal count.
- Adds a registered wrap pulse.
- Used as the digit/field counter of the clock: seconds and minutes are mod-60, hours are mod-24 or mod-12, and units/tens are cascaded through tc.

Parameters:
- WIDTH, 2, count register width in bits.
- MODULUS, 4, number of states; count runs 0..MODULUS-1. Legal range 2 <= MODULUS <= 2**WIDTH; elaboration-time error otherwise.

Ports:
- clk1  in  1  clock; all state updates on rising edge.
- clr  in  1  reset, asynchronous, active-high.
- en  in  1  count enable; advances count one step per clock when high.
- up_dn  in  1  direction: 1 = increment, 0 = decrement.
- load  in  1  synchronous load strobe.
- load_val  in  WIDTH  value to load.
- count  out  WIDTH  current count, registered.
- tc  out  1  combinational terminal count, for cascading.
- wrap  out  1  registered one-cycle pulse following a wrap.
- load_err  out  1  registered one-cycle pulse following an out-of-range load.

Behaviour:
- Reset: clr high forces count=0, wrap=0, load_err=0 immediately, independent of clk1. These values hold while clr is high. First update occurs on the first rising clk1 edge after clr deasserts.
- Priority at each rising edge: clr > load > en > hold.
- Load, when load=1:
  - load_val < MODULUS: count <= load_val, load_err <= 0.
  - load_val >= MODULUS: count <= MODULUS-1, load_err <= 1.
  - en is ignored in that cycle and wrap <= 0.
- Count up (load=0, en=1, up_dn=1): count <= count+1. If count == MODULUS-1, count <= 0 and wrap <= 1.
- Count down (load=0, en=1, up_dn=0): count <= count-1. If count == 0, count <= MODULUS-1 and wrap <= 1.
- Hold (load=0, en=0): count unchanged; wrap <= 0, load_err <= 0.
- wrap and load_err are high for exactly one cycle per event. Back-to-back events give consecutive pulses.
- tc is combinational, with no register delay:
  - tc = en & ~load & (up_dn ? count==MODULUS-1 : count==0).
  - Cascading: the next stage's en is driven from this stage's tc, so both stages step on the same edge.
- Direction change: takes effect on the same edge as the new up_dn value. No state memory of the previous direction.
- Arithmetic: compare and wrap use WIDTH-bit unsigned values. count never leaves 0..MODULUS-1, including when MODULUS < 2**WIDTH.
- MODULUS == 2**WIDTH: behaviour is identical to natural binary rollover.
- Reset mid-operation: clr asserted between edges clears count at once. Any pending wrap/load_err pulse is dropped and tc falls combinationally.

Test Plan:
- Default params (WIDTH=2, MODULUS=4), en=1, up_dn=1, 6 clocks:
  - count 0,1,2,3,0,1.
  - wrap high only in the cycle after 3->0.
  - tc high while count=3.
- WIDTH=6, MODULUS=60:
  - Count up from load 58: count 58,59,0; wrap pulses once; tc high at 59.
  - Switch up_dn=0 at count 0: next count 59, wrap pulses.
- WIDTH=6, MODULUS=60, out-of-range loads:
  - load_val=63: count=59, load_err=1 for one cycle.
  - load_val=60: count=59, load_err pulses.
  - load_val=12: count=12, no load_err.
- load=1 and en=1 together at count 59 (up):
  - count <= load_val=5, wrap stays 0.
  - tc low while load=1.
- Cascade of a mod-10 stage and a mod-6 stage (WIDTH=4), upper en = lower tc, run 60 clocks:
  - Pair goes 00..59 then 00.
  - Upper wrap pulses exactly once.
- Async clr at count=37, asserted between clock edges:
  - count=0, wrap=0, load_err=0 immediately, no edge needed.
  - Held at 0 while clr=1.
  - Counts 1 on the first edge after release.
